// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Purpose : Segment bit indices, digit patterns and FSM state type shared by
//           the seven-segment pattern encoder (SEG7_HEX_EXT_EN adds A..F).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);

  localparam logic [6:0] SEG7_BLANK = 7'h00;
  localparam logic [6:0] SEG7_0 = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [6:0] SEG7_1 = M_B | M_C;
  localparam logic [6:0] SEG7_2 = M_A | M_B | M_D | M_E | M_G;
  localparam logic [6:0] SEG7_3 = M_A | M_B | M_C | M_D | M_G;
  localparam logic [6:0] SEG7_4 = M_B | M_C | M_F | M_G;
  localparam logic [6:0] SEG7_5 = M_A | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG7_6 = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG7_7 = M_A | M_B | M_C;
  localparam logic [6:0] SEG7_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG7_9 = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG7_A = M_A | M_B | M_C | M_E | M_F | M_G;
  localparam logic [6:0] SEG7_B = M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG7_C = M_A | M_D | M_E | M_F;
  localparam logic [6:0] SEG7_D = M_B | M_C | M_D | M_E | M_G;
  localparam logic [6:0] SEG7_E = M_A | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG7_F = M_A | M_E | M_F | M_G;

  typedef logic [0:0] seg7_state_t;
  localparam seg7_state_t ST_IDLE = 1'b0;
  localparam seg7_state_t ST_HOLD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_lut.sv
// ============================================================================
// Module  : seg7_pattern_lut
// Purpose : Combinational segment pattern -> {code, err, blank} lookup;
//           SEG7_HEX_EXT_EN enables the A..F hex glyphs.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] code_o,
  output logic       err_o,
  output logic       blank_o
);

  always_comb begin
    code_o  = 4'h0;
    err_o   = 1'b0;
    blank_o = 1'b0;
    case (pattern_i)
      SEG7_BLANK: blank_o = 1'b1;
      SEG7_0:     code_o  = 4'h0;
      SEG7_1:     code_o  = 4'h1;
      SEG7_2:     code_o  = 4'h2;
      SEG7_3:     code_o  = 4'h3;
      SEG7_4:     code_o  = 4'h4;
      SEG7_5:     code_o  = 4'h5;
      SEG7_6:     code_o  = 4'h6;
      SEG7_7:     code_o  = 4'h7;
      SEG7_8:     code_o  = 4'h8;
      SEG7_9:     code_o  = 4'h9;
`ifdef SEG7_HEX_EXT_EN
      SEG7_A:     code_o  = 4'hA;
      SEG7_B:     code_o  = 4'hB;
      SEG7_C:     code_o  = 4'hC;
      SEG7_D:     code_o  = 4'hD;
      SEG7_E:     code_o  = 4'hE;
      SEG7_F:     code_o  = 4'hF;
`endif
      default:    err_o   = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_pattern_encoder.sv
// ============================================================================
// Module  : seg7_pattern_encoder
// Purpose : Synchronises a 7-segment bus, qualifies stable patterns and hands
//           decoded codes out over valid/ready (SEG7_HEX_EXT_EN: hex A..F).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seg7_pattern_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err,
  output logic       blank,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]       seg_meta_q, seg_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       last_q;
  logic             last_vld_q;
  seg7_state_t      state_q, state_d;
  logic [3:0]       code_q;
  logic             err_q, blank_q;
  logic             overrun_q, overrun_d;
  logic             qualified, is_new, emit;
  logic [3:0]       lut_code;
  logic             lut_err, lut_blank;

  seg7_pattern_lut u_lut (
    .pattern_i (seg_s_q),
    .code_o    (lut_code),
    .err_o     (lut_err),
    .blank_o   (lut_blank)
  );

  // Compare the value seg_s is about to take with its current one, so the
  // counter restarts on the same edge the new pattern lands in seg_s.
  always_comb begin
    cnt_d = cnt_q;
    if (seg_meta_q != seg_s_q) begin
      cnt_d = '0;
    end else if (cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign qualified = (cnt_q == C_CNT_MAX);
  assign is_new    = !last_vld_q || (seg_s_q != last_q);

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    emit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (qualified && is_new) begin
          emit    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else if (qualified && is_new) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_q <= '0;
      seg_s_q    <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      state_q    <= ST_IDLE;
      code_q     <= '0;
      err_q      <= 1'b0;
      blank_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      seg_meta_q <= seg;
      seg_s_q    <= seg_meta_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      overrun_q  <= overrun_d;
      if (emit) begin
        code_q     <= lut_code;
        err_q      <= lut_err;
        blank_q    <= lut_blank;
        last_q     <= seg_s_q;
        last_vld_q <= 1'b1;
      end
    end
  end

  assign code      = code_q;
  assign err       = err_q;
  assign blank     = blank_q;
  assign out_valid = (state_q == ST_HOLD);
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_pattern_encoder.sv
// ============================================================================
// Module  : tb_seg7_pattern_encoder
// Purpose : Scoreboard bench for seg7_pattern_encoder with directed scenarios
//           and randomised bus/backpressure traffic (SEG7_HEX_EXT_EN aware).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_pattern_encoder;

  localparam int S = 4;
`ifdef SEG7_HEX_EXT_EN
  localparam int N_CODES = 16;
`else
  localparam int N_CODES = 10;
`endif

  typedef struct packed {
    logic [3:0] code;
    logic       err;
    logic       blank;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h00;
  logic       out_ready = 1'b0;
  logic [3:0] code;
  logic       err, blank, out_valid, overrun;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  resp_t      exp_q[$];
  logic [6:0] hist[$];
  bit         m_busy = 1'b0, m_lastv = 1'b0, m_ov = 1'b0;
  logic [6:0] m_last = 7'h00;
  resp_t      mon_e;

  always #5 clk = ~clk;

  seg7_pattern_encoder #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .code      (code),
    .err       (err),
    .blank     (blank),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  function automatic resp_t ref_decode(input logic [6:0] p);
    resp_t r;
    r = '0;
    if (p == 7'h00) begin
      r.blank = 1'b1;
      return r;
    end
    for (int i = 0; i < N_CODES; i++) begin
      if (glyph[i] == p) begin
        r.code = 4'(i);
        return r;
      end
    end
    r.err = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchroniser reset values behave like two already-sampled zeros.
  task automatic model_reset();
    hist.delete();
    hist.push_back(7'h00);
    hist.push_back(7'h00);
    m_busy  = 1'b0;
    m_lastv = 1'b0;
    m_ov    = 1'b0;
    exp_q.delete();
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  // Reference: a bus value qualifies once S+1 consecutive edge samples agree;
  // the decision is taken two edges after the newest of those samples.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit         qual;
      logic [6:0] pat;
      hist.push_back(seg);
      if (hist.size() > S + 3) void'(hist.pop_front());
      qual = 1'b0;
      pat  = 7'h00;
      if (hist.size() == S + 3) begin
        pat  = hist[S];
        qual = 1'b1;
        for (int i = 0; i < S; i++) if (hist[i] != pat) qual = 1'b0;
      end
      if (m_busy) begin
        if (out_ready) m_busy = 1'b0;
        else if (qual && pat != m_last) m_ov = 1'b1;
      end else if (qual && (!m_lastv || pat != m_last)) begin
        m_busy  = 1'b1;
        m_last  = pat;
        m_lastv = 1'b1;
        exp_q.push_back(ref_decode(pat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(m_busy));
      check("overrun", 32'(overrun), 32'(m_ov));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: code=%0h err=%0b blank=%0b, scoreboard empty", code, err, blank);
        end else begin
          mon_e = exp_q[0];
          check("code", 32'(code), 32'(mon_e.code));
          check("err", 32'(err), 32'(mon_e.err));
          check("blank", 32'(blank), 32'(mon_e.blank));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // First bus sample is the next edge k; out_valid must appear after k+S+2.
  task automatic measure_latency(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check(name, 32'(n), 32'(S + 3));
  endtask

  initial begin
    #1;
    check("rst_code", 32'(code), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    step(2);

    rst_n = 1'b1;
    seg = 7'h5B;
    out_ready = 1'b1;
    measure_latency("t1_latency");
    step(10);

    seg = 7'h3F; step(10);
    seg = 7'h06; step(2);
    seg = 7'h3F; step(10);

    seg = 7'h12; step(8);
    seg = 7'h00; step(8);

    out_ready = 1'b0;
    seg = 7'h4F; step(8);
    seg = 7'h6F; step(10);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_code_frozen", 32'(code), 32'h3);
    out_ready = 1'b1; step(12);

    out_ready = 1'b0;
    seg = 7'h07; step(10);
    check("t5_code_hold", 32'(code), 32'h7);
    check("t5_valid_hold", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_code", 32'(code), 32'd0);
    check("t5_async_overrun", 32'(overrun), 32'd0);
    step(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    measure_latency("t5_reemit_latency");
    step(4);

    seg = 7'h77; step(10);

    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: seg = glyph[$urandom_range(0, 15)];
        3:       seg = 7'h00;
        4:       seg = 7'($urandom_range(0, 127));
        default: seg = 7'h77;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      step($urandom_range(1, 10));
    end

    out_ready = 1'b1;
    step(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_pattern_encoder.md
Name: seg7_pattern_encoder

Overview:
Inverse of the team's BCD-to-seven-segment decoder. It watches a 7-bit segment bus (a..g, active-high, bit0=a ... bit6=g) and synchronises it. It waits for each new pattern to hold stable for a programmable number of cycles, then converts it back to a 4-bit code. It sits on the readback/self-check path and hands codes to a consumer over a valid/ready handshake.

Parameters:
STABLE_CYCLES, 4, consecutive synchronised cycles a pattern must hold before it qualifies (legal range 1..255).
CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter (derived; do not override).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg  input  7  segment bus, bit0=a .. bit6=g, asynchronous to clk
code  output  4  decoded value
err  output  1  pattern not in the legal table
blank  output  1  pattern was 7'h00
out_valid  output  1  code/err/blank are valid
out_ready  input  1  consumer accepts when high with out_valid
overrun  output  1  sticky: a qualified pattern was held back by backpressure

Behaviour:
- Reset (asynchronous, rst_n=0) clears everything: code=0, err=0, blank=0, out_valid=0, overrun=0, both sync flops=0, counter=0, and the "last-emitted" register is marked invalid.
- seg passes through a 2-flop synchroniser; seg_s is the second flop.
- Stability counter:
  - Cleared when seg_s differs from its previous-cycle value.
  - Otherwise increments and saturates at STABLE_CYCLES.
  - The pattern qualifies when the counter equals STABLE_CYCLES.
- Exact latency: a pattern first sampled at edge k, then held, gives out_valid=1 after edge k+STABLE_CYCLES+2.
- Emission: a qualified pattern is emitted only if it differs from last-emitted, or if last-emitted is invalid. A static pattern emits exactly once.
- Decode table (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 -> blank=1, code=0, err=0.
  - Any other pattern -> err=1, code=0, blank=0.
- FSM, two states:
  - IDLE: out_valid=0. On an emit condition, register code/err/blank, update last-emitted, go to HOLD.
  - HOLD: out_valid=1; code/err/blank are frozen. If out_valid && out_ready, go to IDLE.
  - There is no same-cycle re-emit: a pending new pattern emits on the next cycle, because the counter is already saturated.
- Backpressure: if a different pattern qualifies while in HOLD with out_ready=0, set overrun=1. It stays set until reset. The held output is not overwritten. The pending pattern emits after acceptance only if it is still on the bus.
- A glitch shorter than STABLE_CYCLES is never emitted and does not change last-emitted.
- Reset asserted mid-HOLD drops the pending output immediately. After release, the current bus pattern emits again, since last-emitted is invalid.

Optional Feature:
Macro SEG7_HEX_EXT_EN.
- Defined: the table is extended with A=77, b=7C, C=39, d=5E, E=79, F=71, giving codes A..F with err=0.
- Undefined: those six patterns decode as err=1.

Decomposition:
- Package seg7_pkg holds:
  - segment bit-index constants SEG_A..SEG_G;
  - pattern constants SEG7_0..SEG7_9, SEG7_A..SEG7_F and SEG7_BLANK;
  - the FSM state typedef.
- The decoder block should reuse the package constants.
- One combinational sub-module, seg7_pattern_lut, maps pattern -> {code, err, blank}. The top level holds the synchroniser, counter, FSM and handshake.

Test Plan:
1. Reset, then seg=7'h5B held, out_ready=1 -> out_valid pulses once at edge STABLE_CYCLES+2 (6 with the default) with code=2, err=0. No second pulse while 5B is held.
2. seg=7'h3F held, then a 2-cycle glitch to 7'h06, then back to 3F -> one emission of code=0 only; 06 is never emitted.
3. seg=7'h12 -> err=1, code=0. seg=7'h00 -> blank=1, err=0.
4. out_ready=0, seg=7'h4F qualifies (HOLD, code=3), then seg=7'h6F is held -> overrun=1 and code stays 3. Raise out_ready -> 3 transfers, then code=9 emits on the next out_valid.
5. In HOLD with code=7, pulse rst_n low for one cycle -> all outputs 0 asynchronously. The held 7'h07 re-emits after STABLE_CYCLES+2 edges.
6. With SEG7_HEX_EXT_EN defined, seg=7'h77 -> code=A, err=0. Without it -> err=1.
